text_overlay_renderer: RTL and testbench
========================================

# text_overlay_renderer

Pixel-stream consumer for the on-screen text ROMs: converts the VGA scan position into a character-cell address (`char_xy`), takes the returned ASCII `char_code`, fetches the glyph row from the synchronous 8x16 font ROM and emits a per-pixel `text_on`/`text_rgb` overlay aligned with delayed sync signals. It sits between the VGA sync generator and the pixel mux; the mode-select screen uses it with a 16x1 char ROM and a blinking highlight on the selected word.

## Interface
- `X0`, 192: left pixel column of the text window.
- `Y0`, 240: top pixel row of the text window.
- `ROWS`, 1: character rows in the window (1..16); always 16 columns.
- `BLINK_FRAMES`, 30: frames per blink half-period (>=1).
- `FG_RGB`, 12'hFFF: colour driven when `text_on`=1.
- `clk`  in  1  pixel clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `video_on`  in  1  active-video flag from sync generator.
- `hsync_in`, `vsync_in`  in  1 each  syncs aligned with `pixel_x/y`.
- `pixel_x`, `pixel_y`  in  10 each  current scan position.
- `char_xy`  out  8  `{row[3:0], col[3:0]}` to char ROM (registered).
- `char_code`  in  7  combinational char ROM reply to `char_xy`.
- `font_addr`  out  11  `{char_code, line[3:0]}` to font ROM (combinational from `char_code` and stage-1 line).
- `font_word`  in  8  font ROM data, valid 1 cycle after `font_addr`; bit 7 = leftmost pixel.
- `hl_en`  in  1  highlight enable.
- `hl_first`, `hl_last`  in  4 each  inclusive highlighted column range.
- `text_on`  out  1  overlay pixel lit.
- `text_rgb`  out  12  `FG_RGB` when `text_on`, else 0.
- `video_on_out`, `hsync_out`, `vsync_out`  out  1 each  inputs delayed to match `text_on`.

## Operation
- Region: `in_win` = `video_on` & `X0 <= pixel_x < X0+128` & `Y0 <= pixel_y < Y0+16*ROWS`. Offsets `dx = pixel_x-X0`, `dy = pixel_y-Y0` (10-bit); col = `dx[6:3]`, bit = `dx[2:0]`, row = `dy[7:4]`, line = `dy[3:0]`.
- Stage 1 (registered): `char_xy` <= in_win ? {row,col} : 8'h00; s1_in, s1_bit, s1_line, s1_col, video/sync copies.
- Stage 2 (registered): s2_in, s2_bit, s2_hl = `hl_en & hl_first<=s1_col<=hl_last` (empty if `hl_first>hl_last`), video/sync copies. Font ROM samples `font_addr` on the same edge.
- Stage 3 (registered): pix = `font_word[7-s2_bit]`; `text_on` <= s2_in & (pix ^ (s2_hl & blink_phase)); `text_rgb` <= matching colour; sync/video outputs.
- Blink: `vsync_prev` register; on `vsync_in & ~vsync_prev` (rising edge) increment `frame_cnt`; at `BLINK_FRAMES-1` wrap to 0 and toggle `blink_phase`. Highlighted cells render inverted (whole 8x16 cell, background lit) while `blink_phase`=1.
- Outside window, `text_on`=0 regardless of highlight.

## Timing
- Latency: 3 clk from `pixel_x/y`, `video_on`, syncs to `text_on`, `text_rgb`, `*_out`; all delayed identically.
- `char_xy` valid 1 clk after pixel; `char_code` must settle within that cycle (combinational ROM).
- Reset: `char_xy`=0, `text_on`=0, `text_rgb`=0, `video_on_out`=0, `hsync_out`=0, `vsync_out`=0, all pipeline regs, `frame_cnt`=0, `blink_phase`=0, `vsync_prev`=0. First valid output 3 clk after reset release.
- Reset mid-frame clears pipeline; no stale pixel emitted. `hl_*` changes take effect on pixels sampled at stage 1 from that cycle on.
- `BLINK_FRAMES`=1: phase toggles every vsync rising edge.
- vsync held high does not re-count; only edges count.

## Test plan
- Reset: assert `reset` 2 clk with active stimulus -> all outputs 0; `frame_cnt`/`blink_phase` 0.
- Addressing: pixel (192+8*5+3, 240+7) -> `char_xy`=8'h05 one clk later, `font_addr`={char_code,4'h7}.
- Glyph/latency: model ROM 16x1 "MODE      SELECT", real font; scan line y=245 x=192..319 -> `text_on` reproduces font row of each char, delayed exactly 3 clk; x=191 and x=320 -> 0.
- Blink: `hl_en`=1, `hl_first`=10, `hl_last`=15, `BLINK_FRAMES`=2; 4 vsync edges -> phase toggles after edges 2 and 4; cols 10-15 inverted only in phase 1, cols 0-9 unchanged.
- Sync alignment: random syncs/`video_on` -> `*_out` equal inputs delayed 3 clk; `video_on`=0 inside window -> `text_on`=0.
- Mid-line reset and `hl_first`>`hl_last` -> clean restart, no highlight.

Source files
------------

// File: rtl/text_overlay_renderer.sv
// Text overlay renderer: maps the scan position to a 16-column character window,
// fetches glyph rows from a synchronous font ROM and emits a 3-stage aligned pixel overlay.
module text_overlay_renderer #(
  parameter int          X0           = 192,
  parameter int          Y0           = 240,
  parameter int          ROWS         = 1,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_RGB       = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_word,
  input  logic        hl_en,
  input  logic [3:0]  hl_first,
  input  logic [3:0]  hl_last,
  output logic        text_on,
  output logic [11:0] text_rgb,
  output logic        video_on_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + 128);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + 16 * ROWS);
  localparam int          FCW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] F_LAST = FCW'(BLINK_FRAMES - 1);

  logic [6:0] dx;
  logic [7:0] dy;
  logic       in_win;

  // Only the low offset bits are needed once the window test has passed.
  assign dx = 7'(pixel_x - 10'(X0));
  assign dy = 8'(pixel_y - 10'(Y0));
  assign in_win = video_on
                && ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI)
                && ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);

  logic       s1_in, s1_vid, s1_hs, s1_vs;
  logic [2:0] s1_bit;
  logic [3:0] s1_line, s1_col;

  // NOTE: every pipeline register uses <= so all stages sample the previous-cycle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      char_xy <= 8'h00;
      s1_in   <= 1'b0;
      s1_bit  <= 3'd0;
      s1_line <= 4'd0;
      s1_col  <= 4'd0;
      s1_vid  <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
    end else begin
      char_xy <= in_win ? {dy[7:4], dx[6:3]} : 8'h00;
      s1_in   <= in_win;
      s1_bit  <= dx[2:0];
      s1_line <= dy[3:0];
      s1_col  <= dx[6:3];
      s1_vid  <= video_on;
      s1_hs   <= hsync_in;
      s1_vs   <= vsync_in;
    end
  end

  assign font_addr = {char_code, s1_line};

  logic       s2_in, s2_hl, s2_vid, s2_hs, s2_vs;
  logic [2:0] s2_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_in  <= 1'b0;
      s2_hl  <= 1'b0;
      s2_bit <= 3'd0;
      s2_vid <= 1'b0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
    end else begin
      s2_in  <= s1_in;
      s2_hl  <= hl_en && (s1_col >= hl_first) && (s1_col <= hl_last);
      s2_bit <= s1_bit;
      s2_vid <= s1_vid;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
    end
  end

  logic       vsync_prev, blink_phase;
  logic [FCW-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev  <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_in && !vsync_prev) begin
        if (frame_cnt == F_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  logic pix, lit;

  // Highlighted cells invert during the lit blink phase, so the cell background glows.
  assign pix = font_word[3'd7 - s2_bit];
  assign lit = s2_in & (pix ^ (s2_hl & blink_phase));

  always_ff @(posedge clk) begin
    if (reset) begin
      text_on      <= 1'b0;
      text_rgb     <= 12'h000;
      video_on_out <= 1'b0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
    end else begin
      text_on      <= lit;
      text_rgb     <= lit ? FG_RGB : 12'h000;
      video_on_out <= s2_vid;
      hsync_out    <= s2_hs;
      vsync_out    <= s2_vs;
    end
  end

endmodule

// File: tb/tb_text_overlay_renderer.sv
// Directed bench for text_overlay_renderer: char/font ROM models, a per-pixel expectation
// queue three clocks deep, blink, sync alignment and mid-line reset steps.
module tb_text_overlay_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_word = '0;
  logic        hl_en = 1'b0;
  logic [3:0]  hl_first = '0, hl_last = '0;
  logic        text_on;
  logic [11:0] text_rgb;
  logic        video_on_out, hsync_out, vsync_out;

  always #5 clk = ~clk;

  text_overlay_renderer #(.X0(192), .Y0(240), .ROWS(1), .BLINK_FRAMES(2), .FG_RGB(12'hFFF)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .char_xy(char_xy), .char_code(char_code),
    .font_addr(font_addr), .font_word(font_word), .hl_en(hl_en), .hl_first(hl_first),
    .hl_last(hl_last), .text_on(text_on), .text_rgb(text_rgb), .video_on_out(video_on_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  function automatic logic [6:0] char_at(input logic [3:0] c);
    string s;
    byte   b;
    s = "MODE      SELECT";
    b = s.getc(int'(c));
    return b[6:0];
  endfunction

  // Synthetic glyph table: asymmetric per line so bit-order errors show up.
  function automatic logic [7:0] font_fn(input logic [6:0] code, input logic [3:0] line);
    return {code, 1'b0} ^ (8'(line) * 8'd37);
  endfunction

  always_comb char_code = char_at(char_xy[3:0]);
  always @(posedge clk) font_word <= font_fn(font_addr[10:4], font_addr[3:0]);

  typedef struct packed {
    logic on_known;
    logic lit;
    logic vid, hs, vs;
  } exp_t;

  exp_t q[$];
  int   passed = 0, failed = 0, total = 0;
  logic vsp_m = 1'b0, phase_m = 1'b0, cnt_m = 1'b0;
  logic chk_lit = 1'b1;
  string step_name = "init";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s/%s: observed %0h expected %0h", step_name, tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    int   x, y;
    logic in, pix, hl;
    logic [3:0] col, line;
    logic [2:0] bpos;
    logic [7:0] f;
    x = int'(pixel_x);
    y = int'(pixel_y);
    in = video_on && x >= 192 && x < 320 && y >= 240 && y < 256;
    col  = 4'((x - 192) >> 3);
    bpos = 3'(x - 192);
    line = 4'(y - 240);
    f    = font_fn(char_at(col), line);
    pix  = f[3'd7 - bpos];
    hl   = hl_en && col >= hl_first && col <= hl_last;
    if (vsync_in && !vsp_m) begin
      if (cnt_m) begin cnt_m = 1'b0; phase_m = ~phase_m; end
      else cnt_m = 1'b1;
    end
    vsp_m = vsync_in;
    e.on_known = !in || chk_lit;
    e.lit = in && (pix ^ (hl && phase_m));
    e.vid = video_on; e.hs = hsync_in; e.vs = vsync_in;
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      if (e.on_known) begin
        chk("text_on", 32'(text_on), 32'(e.lit));
        chk("text_rgb", 32'(text_rgb), e.lit ? 32'hFFF : 32'h0);
      end
      chk("video_on_out", 32'(video_on_out), 32'(e.vid));
      chk("hsync_out", 32'(hsync_out), 32'(e.hs));
      chk("vsync_out", 32'(vsync_out), 32'(e.vs));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_char_xy", 32'(char_xy), 32'h0);
    chk("rst_text_on", 32'(text_on), 32'h0);
    chk("rst_text_rgb", 32'(text_rgb), 32'h0);
    chk("rst_video_on_out", 32'(video_on_out), 32'h0);
    chk("rst_hsync_out", 32'(hsync_out), 32'h0);
    chk("rst_vsync_out", 32'(vsync_out), 32'h0);
    reset = 1'b0;
    q.delete();
    repeat (2) q.push_back('{on_known: 1'b1, lit: 1'b0, vid: 1'b0, hs: 1'b0, vs: 1'b0});
    vsp_m = 1'b0; cnt_m = 1'b0; phase_m = 1'b0;
  endtask

  task automatic scan_line(input int y, input int x_start, input int x_stop);
    pixel_y = 10'(y);
    video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    for (int x = x_start; x <= x_stop; x++) begin
      pixel_x = 10'(x);
      tick();
    end
    video_on = 1'b0;
    repeat (3) tick();
  endtask

  task automatic vsync_pulse();
    video_on = 1'b0; pixel_y = 10'd0; pixel_x = 10'd0;
    vsync_in = 1'b1;
    repeat (3) tick();
    vsync_in = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    step_name = "reset";
    pixel_x = 10'd200; pixel_y = 10'd245; video_on = 1'b1; hsync_in = 1'b1;
    do_reset();
    hsync_in = 1'b0;

    step_name = "addressing";
    pixel_x = 10'(192 + 8 * 5 + 3); pixel_y = 10'(240 + 7); video_on = 1'b1;
    tick();
    chk("char_xy", 32'(char_xy), 32'h05);
    chk("font_addr", 32'(font_addr), 32'h207);
    video_on = 1'b0;
    repeat (3) tick();

    step_name = "glyph_y245";
    scan_line(245, 188, 323);
    step_name = "glyph_y240";
    scan_line(240, 190, 200);
    step_name = "glyph_y255";
    scan_line(255, 314, 322);

    hl_en = 1'b1; hl_first = 4'd10; hl_last = 4'd15;
    step_name = "blink_edge0";
    scan_line(245, 188, 323);
    for (int k = 1; k <= 4; k++) begin
      vsync_pulse();
      step_name = $sformatf("blink_edge%0d", k);
      scan_line(245, 188, 323);
    end

    step_name = "sync_random";
    pixel_x = 10'd250; pixel_y = 10'd245;
    chk_lit = 1'b0;
    for (int i = 0; i < 48; i++) begin
      video_on = 1'($urandom_range(1));
      hsync_in = 1'($urandom_range(1));
      vsync_in = 1'($urandom_range(1));
      tick();
    end
    vsync_in = 1'b0; hsync_in = 1'b0; video_on = 1'b0;
    repeat (3) tick();
    chk_lit = 1'b1;
    step_name = "video_off_in_window";
    pixel_x = 10'd200; pixel_y = 10'd245; video_on = 1'b0;
    repeat (4) tick();

    step_name = "pre_reset_blink";
    for (int i = 0; i < 4 && !(phase_m && cnt_m); i++) vsync_pulse();
    scan_line(245, 188, 260);
    step_name = "midline_reset";
    hl_first = 4'd12; hl_last = 4'd3;
    pixel_x = 10'd270; pixel_y = 10'd245; video_on = 1'b1;
    do_reset();
    step_name = "empty_highlight";
    scan_line(245, 188, 323);
    hl_first = 4'd10; hl_last = 4'd15;
    vsync_pulse();
    step_name = "post_reset_one_edge";
    scan_line(245, 188, 323);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
